demux_rr_l2: RTL and testbench
==============================

// Module: demux_rr_l2
// PURPOSE
//  Parametrised successor of the 1:2 lane demux: distributes valid words from one serial stream
//  round-robin over NUM_CH output lanes, lane 0 first.
//  Sits in phy_rx after the byte-unstriping stage, feeding per-lane FIFOs.
//  Adds an aligned-burst mode and inter-word gap supervision with partial-group abort.
// PARAMETERS
//  DATA_W   8  word width in bits
//  NUM_CH   2  output lane count; legal range >= 2
//  ALIGN    1  0 = per-lane immediate release; 1 = release all lanes together when a group is complete
//  GAP_MAX  4  max consecutive invalid cycles tolerated inside a partial group; legal range >= 1
//  CNT_W    8  drop counter width; used only with DEMUX_STATS_EN
// PORTS
//  clk_4f     in   1              single clock, rising edge
//  reset      in   1              asynchronous, active-high
//  data_in    in   DATA_W         input word
//  valid_in   in   1              data_in is valid this cycle
//  data_out   out  NUM_CH*DATA_W  lane k = bits [k*DATA_W +: DATA_W]; registered
//  valid_out  out  NUM_CH         per-lane valid; registered
//  err_abort  out  1              one-cycle pulse when a partial group is aborted
//  drop_cnt   out  CNT_W          aborted-group count; port exists only with DEMUX_STATS_EN
// BEHAVIOUR
//  Reset (async assert): ptr=0, gap=0, state=IDLE, data_out=0, valid_out=0, err_abort=0, drop_cnt=0.
//  - Partial group discarded silently on reset: no err_abort pulse, no drop_cnt increment.
//  ptr (width $clog2(NUM_CH)) advances only on valid_in=1. Invalid cycles never advance ptr.
//  ptr wraps from NUM_CH-1 to 0.
//  FSM states:
//  - IDLE: ptr==0, no partial group.
//    IDLE->FILL on valid_in.
//    NUM_CH words arriving back-to-back complete a group and return FSM to IDLE.
//  - FILL: 0<ptr<NUM_CH.
//    valid_in stores word at lane ptr; gap<=0; ptr++.
//    Group complete when ptr was NUM_CH-1: ptr<=0, state->IDLE.
//    valid_in=0: gap++.
//    gap reaches GAP_MAX with valid_in=0: abort group: ptr<=0, gap<=0, err_abort=1 next cycle, ->IDLE.
//  - Simultaneous case: valid_in=1 in the cycle the gap would hit GAP_MAX means the word is
//    accepted normally; no abort.
//  - gap counts only in FILL; in IDLE gap stays 0.
//  ALIGN=0:
//  - Word accepted at cycle t appears on its lane at t+1 with valid_out[lane]=1 for exactly one cycle.
//  - data_out lane holds its value until that lane's next word.
//  - Abort does not retract already-released lanes.
//  ALIGN=1:
//  - Words are staged internally.
//  - When the final lane's word is accepted at t, all lanes load at t+1 and valid_out is all ones
//    for one cycle.
//  - Aborted partial group is never released; data_out keeps the previous group.
//  valid_out is 0 in every cycle not listed above. Output latency is 1 cycle in both modes.
// CONFIGURATION
//  DEMUX_STATS_EN defined:
//  - drop_cnt port present; increments on every abort; saturates at 2^CNT_W-1.
//  - Not incremented by reset discard.
//  DEMUX_STATS_EN undefined: drop_cnt port and counter absent; all other behaviour identical.
// TESTING
//  1) NUM_CH=2, ALIGN=0, valid words 0xA1,0xB2 back-to-back
//     -> lane0=0xA1 valid_out=01, then lane1=0xB2 valid_out=10.
//  2) NUM_CH=4, ALIGN=1, 0x10..0x13 with 2 invalid cycles between words 1 and 2
//     -> one cycle valid_out=1111, data_out=0x13121110; no err_abort.
//  3) NUM_CH=4, ALIGN=1, GAP_MAX=4, words 0x10,0x11 then 4 invalid cycles
//     -> err_abort single pulse, valid_out stays 0000, ptr back to 0.
//     Next 4 words 0x20..0x23 -> released as lanes 0..3.
//  4) Gap boundary: 3 invalid cycles, then valid on the 4th (GAP_MAX=4) -> word accepted, no abort.
//  5) Reset asserted mid-group after 2 of 4 words -> outputs 0 immediately, no err_abort.
//     Next word lands on lane 0.
//  6) DEMUX_STATS_EN, CNT_W=2, 5 forced aborts -> drop_cnt sequence 1,2,3,3,3.
//     Rebuild without macro -> port absent, tests 1-5 pass.

Source files
------------

// File: rtl/demux_rr_l2.sv
// rtl/demux_rr_l2.sv - round-robin 1:NUM_CH word demux with aligned-burst mode and gap abort
//
// Distributes valid words from one serial stream over NUM_CH output lanes, lane 0 first.
// ALIGN=0 releases each word on its lane one cycle after acceptance; ALIGN=1 stages a
// whole group and releases all lanes together. A partial group that sees GAP_MAX
// consecutive invalid cycles is aborted (err_abort pulse, pointer back to lane 0).
//
// Optional feature macro: DEMUX_STATS_EN adds the saturating drop_cnt output.
//
// Ports:
//   clk_4f     in   1              clock, rising edge
//   reset      in   1              asynchronous, active-high
//   data_in    in   DATA_W         input word
//   valid_in   in   1              data_in valid this cycle
//   data_out   out  NUM_CH*DATA_W  lane k = bits [k*DATA_W +: DATA_W], registered
//   valid_out  out  NUM_CH         per-lane valid, registered
//   err_abort  out  1              one-cycle pulse after a partial group is aborted
//   drop_cnt   out  CNT_W          aborted-group count (DEMUX_STATS_EN only)
module demux_rr_l2 #(
  parameter int DATA_W  = 8,
  parameter int NUM_CH  = 2,
  parameter int ALIGN   = 1,
  parameter int GAP_MAX = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        valid_out,
`ifdef DEMUX_STATS_EN
  output logic                     err_abort,
  output logic [CNT_W-1:0]         drop_cnt
`else
  output logic                     err_abort
`endif
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GAP_W = $clog2(GAP_MAX + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  logic [0:0]               state;
  logic [PTR_W-1:0]         ptr;
  logic [GAP_W-1:0]         gap;
  logic [NUM_CH*DATA_W-1:0] stage;
  logic [NUM_CH*DATA_W-1:0] release_vec;
  logic                     last;
  logic                     abort;

  assign last = (ptr == PTR_W'(NUM_CH - 1));

  // The abort fires on the invalid cycle that would bring gap up to GAP_MAX;
  // a valid word in that same cycle wins and is accepted normally.
  assign abort = (state == S_FILL) && !valid_in && (gap == GAP_W'(GAP_MAX - 1));

  // Final lane bypasses the staging register so the whole group loads in one edge.
  always_comb begin
    release_vec = stage;
    release_vec[(NUM_CH-1)*DATA_W +: DATA_W] = data_in;
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gap       <= '0;
      stage     <= '0;
      data_out  <= '0;
      valid_out <= '0;
      err_abort <= 1'b0;
    end else begin
      valid_out <= '0;
      err_abort <= abort;

      if (valid_in) begin
        gap <= '0;
        stage[int'(ptr)*DATA_W +: DATA_W] <= data_in;
        if (last) begin
          ptr   <= '0;
          state <= S_IDLE;
        end else begin
          ptr   <= ptr + PTR_W'(1);
          state <= S_FILL;
        end
      end else if (abort) begin
        ptr   <= '0;
        gap   <= '0;
        state <= S_IDLE;
      end else if (state == S_FILL) begin
        gap <= gap + GAP_W'(1);
      end

      if (ALIGN == 0) begin
        if (valid_in) begin
          data_out[int'(ptr)*DATA_W +: DATA_W] <= data_in;
          valid_out <= NUM_CH'(1) << ptr;
        end
      end else begin
        // Aborted groups never reach data_out; it keeps the last full group.
        if (valid_in && last) begin
          data_out  <= release_vec;
          valid_out <= '1;
        end
      end
    end
  end

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (abort && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux_rr_l2.sv
// tb/tb_demux_rr_l2.sv - scoreboard bench for demux_rr_l2 (2-lane ALIGN=0 and 4-lane ALIGN=1)
module tb_demux_rr_l2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DUT A: NUM_CH=2, ALIGN=0, GAP_MAX=4
  logic        rst_a = 1'b1;
  logic [7:0]  din_a = '0;
  logic        vin_a = 1'b0;
  logic [15:0] dout_a;
  logic [1:0]  vout_a;
  logic        abrt_a;
`ifdef DEMUX_STATS_EN
  logic [7:0]  dcnt_a;
`endif

  // DUT B: NUM_CH=4, ALIGN=1, GAP_MAX=4, CNT_W=2
  logic        rst_b = 1'b1;
  logic [7:0]  din_b = '0;
  logic        vin_b = 1'b0;
  logic [31:0] dout_b;
  logic [3:0]  vout_b;
  logic        abrt_b;
`ifdef DEMUX_STATS_EN
  logic [1:0]  dcnt_b;
`endif

  demux_rr_l2 #(.DATA_W(8), .NUM_CH(2), .ALIGN(0), .GAP_MAX(4), .CNT_W(8)) dut_a (
    .clk_4f(clk), .reset(rst_a), .data_in(din_a), .valid_in(vin_a),
    .data_out(dout_a), .valid_out(vout_a),
`ifdef DEMUX_STATS_EN
    .err_abort(abrt_a), .drop_cnt(dcnt_a)
`else
    .err_abort(abrt_a)
`endif
  );

  demux_rr_l2 #(.DATA_W(8), .NUM_CH(4), .ALIGN(1), .GAP_MAX(4), .CNT_W(2)) dut_b (
    .clk_4f(clk), .reset(rst_b), .data_in(din_b), .valid_in(vin_b),
    .data_out(dout_b), .valid_out(vout_b),
`ifdef DEMUX_STATS_EN
    .err_abort(abrt_b), .drop_cnt(dcnt_b)
`else
    .err_abort(abrt_b)
`endif
  );

  // Expected output events: {err_abort, valid_out, data_out}
  logic [18:0] exp_a[$];
  logic [36:0] exp_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: any output event on a lane or err_abort must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst_a && (vout_a != 0 || abrt_a)) begin
      if (exp_a.size() == 0) check("a_unexpected_event", {45'd0, abrt_a, vout_a, dout_a}, 64'hDEAD);
      else check("a_event", {45'd0, abrt_a, vout_a, dout_a}, {45'd0, exp_a.pop_front()});
    end
    if (!rst_b && (vout_b != 0 || abrt_b)) begin
      if (exp_b.size() == 0) check("b_unexpected_event", {27'd0, abrt_b, vout_b, dout_b}, 64'hDEAD);
      else check("b_event", {27'd0, abrt_b, vout_b, dout_b}, {27'd0, exp_b.pop_front()});
    end
  end

  task automatic wa(input logic [7:0] d);
    din_a = d; vin_a = 1'b1;
    @(posedge clk); #1;
    vin_a = 1'b0;
  endtask

  task automatic wb(input logic [7:0] d);
    din_b = d; vin_b = 1'b1;
    @(posedge clk); #1;
    vin_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1;
    check("a_reset_data", {48'd0, dout_a}, 64'd0);
    check("a_reset_valid", {62'd0, vout_a}, 64'd0);
    check("b_reset_data", {32'd0, dout_b}, 64'd0);
    check("b_reset_abort", {63'd0, abrt_b}, 64'd0);
`ifdef DEMUX_STATS_EN
    check("b_reset_drop", {62'd0, dcnt_b}, 64'd0);
`endif
    @(negedge clk); rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;

    // DUT A: back-to-back pair
    exp_a.push_back({1'b0, 2'b01, 16'h00A1});
    exp_a.push_back({1'b0, 2'b10, 16'hB2A1});
    wa(8'hA1); wa(8'hB2); idle(2);

    // DUT A: abort after lane 0 released; released lane is kept
    exp_a.push_back({1'b0, 2'b01, 16'hB2C3});
    exp_a.push_back({1'b1, 2'b00, 16'hB2C3});
    wa(8'hC3); idle(6);
    exp_a.push_back({1'b0, 2'b01, 16'hB2D4});
    exp_a.push_back({1'b0, 2'b10, 16'hE5D4});
    wa(8'hD4); wa(8'hE5); idle(2);

    // DUT A: gap boundary, 3 invalid then valid
    exp_a.push_back({1'b0, 2'b01, 16'hE5F6});
    exp_a.push_back({1'b0, 2'b10, 16'h07F6});
    wa(8'hF6); idle(3); wa(8'h07); idle(3);

    // DUT B: group with 2-cycle gap
    exp_b.push_back({1'b0, 4'b1111, 32'h13121110});
    wb(8'h10); wb(8'h11); idle(2); wb(8'h12); wb(8'h13); idle(2);

    // DUT B: abort, then next group lands on lanes 0..3
    exp_b.push_back({1'b1, 4'b0000, 32'h13121110});
    wb(8'h10); wb(8'h11); idle(6);
    exp_b.push_back({1'b0, 4'b1111, 32'h23222120});
    wb(8'h20); wb(8'h21); wb(8'h22); wb(8'h23); idle(2);

    // DUT B: gap boundary
    exp_b.push_back({1'b0, 4'b1111, 32'h43424140});
    wb(8'h40); idle(3); wb(8'h41); wb(8'h42); wb(8'h43); idle(2);

`ifdef DEMUX_STATS_EN
    // DUT B: saturating drop counter with CNT_W=2
    begin
      logic [1:0] exp_cnt [5];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
        exp_b.push_back({1'b1, 4'b0000, 32'h43424140});
        wb(8'h70); idle(6);
        check("b_drop_cnt", {62'd0, dcnt_b}, {62'd0, exp_cnt[i]});
      end
    end
`endif

    // DUT B: reset mid-group
    wb(8'h50); wb(8'h51);
    #2 rst_b = 1'b1;
    #1;
    check("b_midreset_data", {32'd0, dout_b}, 64'd0);
    check("b_midreset_valid", {60'd0, vout_b}, 64'd0);
    check("b_midreset_abort", {63'd0, abrt_b}, 64'd0);
`ifdef DEMUX_STATS_EN
    check("b_midreset_drop", {62'd0, dcnt_b}, 64'd0);
`endif
    @(negedge clk); rst_b = 1'b0;
    @(posedge clk); #1;
    exp_b.push_back({1'b0, 4'b1111, 32'h63626160});
    wb(8'h60); wb(8'h61); wb(8'h62); wb(8'h63); idle(8);

    check("a_queue_drained", 64'(exp_a.size()), 64'd0);
    check("b_queue_drained", 64'(exp_b.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
